// File: rtl/sparse_mask_index_serializer_pkg.sv
// Shared NOU definitions for the sparse mask index serializer.
package sparse_mask_index_serializer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Number of bits needed to express any bit position of an n-bit mask.
    function automatic int index_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int NOU_VECTOR_LENGTH = 8;
    localparam int NOU_INDEX_BITS    = index_bits(NOU_VECTOR_LENGTH);

endpackage

// File: rtl/find_first_one_index_forward.sv
// Forward priority encoder: reports the position of the lowest set bit.
module find_first_one_index_forward #(
    parameter int VECTOR_LENGTH    = 8,
    parameter int MAX_OUTPUT_WIDTH = 16
) (
    input  logic [VECTOR_LENGTH-1:0]    vector_in,
    output logic                        one_is_found_out,
    output logic [MAX_OUTPUT_WIDTH-1:0] first_one_index_out
);

    // Scan from the top down so the lowest set bit is the final winner.
    always_comb begin
        one_is_found_out    = 1'b0;
        first_one_index_out = '0;
        for (int unsigned i = VECTOR_LENGTH; i > 0; i--) begin
            if (vector_in[i-1]) begin
                one_is_found_out    = 1'b1;
                first_one_index_out = MAX_OUTPUT_WIDTH'(i - 1);
            end
        end
    end

endmodule

// File: rtl/sparse_mask_index_serializer.sv
// Serializes the set-bit positions of a captured mask, lowest first,
// one index per downstream handshake.
module sparse_mask_index_serializer
    import sparse_mask_index_serializer_pkg::*;
#(
    parameter int VECTOR_LENGTH    = 8,
    parameter int MAX_OUTPUT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_in,
    input  logic                        mask_valid_in,
    input  logic [VECTOR_LENGTH-1:0]    mask_in,
    output logic                        mask_ready_out,
    output logic                        index_valid_out,
    output logic [MAX_OUTPUT_WIDTH-1:0] index_out,
    output logic [MAX_OUTPUT_WIDTH-1:0] index_seq_out,
    output logic                        index_last_out,
    output logic                        index_empty_out,
    input  logic                        index_ready_in
);

    localparam int INDEX_BITS = index_bits(VECTOR_LENGTH);

    if (MAX_OUTPUT_WIDTH < INDEX_BITS) begin : g_width_check
        $error("MAX_OUTPUT_WIDTH too narrow for VECTOR_LENGTH");
    end

    state_t                      state_q, state_d;
    logic [VECTOR_LENGTH-1:0]    work_q, work_d;
    logic [MAX_OUTPUT_WIDTH-1:0] seq_q, seq_d;
    logic                        empty_flag_q, empty_flag_d;

    logic                        one_found;
    logic [MAX_OUTPUT_WIDTH-1:0] first_index;
    logic                        in_scan;
    logic                        at_most_one;
    logic                        handshake;

    find_first_one_index_forward #(
        .VECTOR_LENGTH    (VECTOR_LENGTH),
        .MAX_OUTPUT_WIDTH (MAX_OUTPUT_WIDTH)
    ) u_ffo (
        .vector_in           (work_q),
        .one_is_found_out    (one_found),
        .first_one_index_out (first_index)
    );

    assign in_scan     = (state_q == SCAN);
    assign at_most_one = ((work_q & (work_q - 1'b1)) == '0);
    assign handshake   = in_scan && index_ready_in;

    // Outputs come from registered state only; idle values are forced to zero.
    assign index_valid_out = in_scan;
    assign index_out       = in_scan ? first_index : '0;
    assign index_seq_out   = in_scan ? seq_q : '0;
    assign index_last_out  = in_scan && at_most_one;
    assign index_empty_out = in_scan && empty_flag_q;

    // State and working-copy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            work_q       <= '0;
            seq_q        <= '0;
            empty_flag_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            work_q       <= work_d;
            seq_q        <= seq_d;
            empty_flag_q <= empty_flag_d;
        end
    end

    // Next-state logic: accept in IDLE, consume one bit per handshake in SCAN.
    always_comb begin
        state_d        = state_q;
        work_d         = work_q;
        seq_d          = seq_q;
        empty_flag_d   = empty_flag_q;
        mask_ready_out = 1'b0;

        case (state_q)
            IDLE: begin
                mask_ready_out = !flush_in;
                if (mask_valid_in && !flush_in) begin
                    work_d       = mask_in;
                    seq_d        = '0;
                    empty_flag_d = (mask_in == '0);
                    state_d      = SCAN;
                end
            end
            SCAN: begin
                if (handshake) begin
                    // Clearing the lowest set bit is the bit at index_out.
                    work_d = work_q & (work_q - 1'b1);
                    seq_d  = seq_q + MAX_OUTPUT_WIDTH'(1);
                    if (at_most_one) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A handshake coinciding with flush still counts; nothing follows it.
        if (flush_in) begin
            state_d      = IDLE;
            work_d       = '0;
            seq_d        = '0;
            empty_flag_d = 1'b0;
        end
    end

    found_matches_empty: assert property (
        @(posedge clk) disable iff (rst) in_scan |-> (one_found == !empty_flag_q)
    );

endmodule

// File: doc/sparse_mask_index_serializer.md
Name: sparse_mask_index_serializer

Overview:
- Downstream consumer of a one-hot/sparse mask: accepts a VECTOR_LENGTH-bit mask per frame and emits the index of every set bit, lowest first, one index per handshake.
- Sits in the NOU between mask generation (non-zero detection) and the sparse operand fetch path.
- Per-frame scanning uses the existing forward find-first-one priority encoder on an internally held working copy of the mask.

Parameters:
- VECTOR_LENGTH, 8, mask width in bits.
- MAX_OUTPUT_WIDTH, 16, width of index and sequence outputs; must satisfy 2**MAX_OUTPUT_WIDTH >= VECTOR_LENGTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush_in  input  1  synchronous abort of the current frame.
- mask_valid_in  input  1  upstream mask valid.
- mask_in  input  VECTOR_LENGTH  mask to serialize.
- mask_ready_out  output  1  block can accept a mask.
- index_valid_out  output  1  index beat valid.
- index_out  output  MAX_OUTPUT_WIDTH  bit position of the current lowest set bit.
- index_seq_out  output  MAX_OUTPUT_WIDTH  beat number within the frame, starting at 0.
- index_last_out  output  1  final beat of the frame.
- index_empty_out  output  1  frame mask was all-zero; beat carries no index.
- index_ready_in  input  1  downstream accepts the beat.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; working mask=0; seq counter=0; empty flag=0.
  - Outputs: mask_ready_out=1, index_valid_out=0, index_out=0, index_seq_out=0, index_last_out=0, index_empty_out=0.
- States: IDLE, SCAN.
- IDLE:
  - mask_ready_out=1, index_valid_out=0.
  - On mask_valid_in=1:
    - capture mask_in into the working mask.
    - clear the seq counter.
    - set empty flag = (mask_in==0).
    - go to SCAN.
- SCAN:
  - mask_ready_out=0, index_valid_out=1.
  - index_out = priority-encoder index of the lowest set bit of the working mask; 0 when the mask is empty.
  - index_last_out = 1 when the working mask has at most one bit set, i.e. (work & (work-1))==0.
  - index_empty_out = empty flag.
  - index_seq_out = seq counter.
  - On handshake (index_valid_out & index_ready_in):
    - clear the bit at index_out in the working mask.
    - increment the seq counter.
    - if index_last_out=1, go to IDLE.
- Output hold: while index_ready_in=0, all index_* outputs stay stable. Outputs derive only from registered state.
- Latency and throughput:
  - First beat is valid the cycle after mask acceptance.
  - A mask with K set bits takes K handshake cycles, plus one IDLE cycle before the next mask is accepted.
  - Maximum throughput is 1 index/cycle within a frame.
- All-zero mask: exactly one beat with index_empty_out=1, index_last_out=1, index_out=0, index_seq_out=0.
- flush_in=1 (synchronous, any state): next state IDLE; working mask, seq counter and empty flag cleared.
  - In IDLE, flush_in suppresses acceptance, so mask_ready_out must read 0 while flush_in=1.
  - If flush_in coincides with a SCAN handshake, that beat counts as delivered; no further beats follow.
- Mid-frame rst: frame abandoned immediately; no partial beats after reset deasserts.
- Seq counter width is MAX_OUTPUT_WIDTH. It never wraps, because beats per frame ≤ VECTOR_LENGTH.
- mask_in is sampled only on acceptance; changes at other times are ignored.

Decomposition:
- Shared NOU package:
  - state enum (IDLE, SCAN) as a typedef.
  - localparam for the index width check (clog2 of VECTOR_LENGTH).
- One sub-module: find_first_one_index_forward, instantiated on the working mask with matching VECTOR_LENGTH/MAX_OUTPUT_WIDTH.
  - Its one_is_found_out is unused in SCAN except as an assertion cross-check: found == !empty flag.

Test Plan:
- Mask 8'b1001_0100, index_ready_in=1 -> beats index 2,4,7; seq 0,1,2; last only on 7; empty=0. mask_ready_out returns to 1 the cycle after the beat with index 7.
- Mask 8'h00 -> single beat: index 0, seq 0, last=1, empty=1; then IDLE.
- Mask 8'hFF with index_ready_in low for 3 cycles on beat 0, then high -> index 0 held stable 4 cycles; then 1..7 on consecutive cycles; last on 7.
- Mask 8'b0110_0001, flush_in pulsed in the cycle beat index 5 handshakes -> beats 0,5 observed, 6 never emitted; mask_ready_out=1 next cycle.
- Mask 8'b1000_0001, rst asserted asynchronously mid-cycle after beat 0 -> index_valid_out drops immediately. After rst release, a new mask 8'b0000_0010 yields a single beat: index 1, seq 0, last=1.
- Back-to-back masks 8'h01, 8'h80 with mask_valid_in held high -> beats (0,last), one IDLE cycle, (7,last).
